mindfocus_unidade_controle: RTL and testbench
=============================================

// Module: mindfocus_unidade_controle
// PURPOSE
//  Control FSM that sequences the mindfocus game datapath: round counter, play register, memory compare, hit counter.
//  Turns iniciar, button activity and compare results into one-cycle control strobes, enforcing a per-play timeout.
//  Sits beside the datapath inside jogo_mindfocus; pronto and db_estado go to the top-level outputs.
// PARAMETERS
//  TIMEOUT_CICLOS  5000  clock cycles allowed per play in ESPERA (5 s at 1 kHz); legal range >= 2
//  TW              13    timeout counter width; must satisfy 2**TW > TIMEOUT_CICLOS
// PORTS
//  clock          in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-low reset
//  iniciar        in   1  start request, level
//  tem_jogada     in   1  level: OR of botoes[3:0] from datapath
//  igual          in   1  registered play == memory word at current index
//  fim_contagem   in   1  round counter is at last index
//  zera_contador  out  1  clear round counter
//  conta_contador out  1  increment round counter
//  zera_registro  out  1  clear play register
//  registra       out  1  load play register from botoes
//  zera_acertos   out  1  clear hit counter
//  conta_acertos  out  1  increment hit counter
//  pronto         out  1  game finished, held in FIM
//  db_timeout     out  1  one-cycle pulse when a play times out
//  db_estado      out  4  current state code
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from registered state only (db_timeout from registered timeout flag).
//  - reset=0: asynchronously forces INICIAL and timer=0; every output 0, db_estado=4'h0. Valid mid-game.
//  - States and transitions:
//    INICIAL  4'h0: idle; iniciar=1 -> PREPARA
//    PREPARA  4'h1: zera_contador=zera_registro=zera_acertos=1 -> ESPERA
//    ESPERA   4'h2: timer increments each cycle
//                   tem_jogada=1 -> REGISTRA
//                   else timer==TIMEOUT_CICLOS-1 -> AVANCA, db_timeout=1 on next cycle
//    REGISTRA 4'h3: registra=1 -> SOLTA
//    SOLTA    4'h4: wait for button release; tem_jogada=0 -> COMPARA
//    COMPARA  4'h5: igual=1 -> ACERTO; igual=0 -> AVANCA
//    ACERTO   4'h6: conta_acertos=1 -> AVANCA
//    AVANCA   4'h7: fim_contagem=1 -> FIM; else -> PROXIMA
//    PROXIMA  4'h8: conta_contador=1 -> ESPERA
//    FIM      4'hF: pronto=1; iniciar=1 -> PREPARA (new game)
//  - Timer: cleared on every entry to ESPERA, counts only while in ESPERA, saturates; width TW.
//  - Timed-out play counts as a miss: no registra, no conta_acertos; round still advances.
//  - Simultaneous tem_jogada=1 and timeout in ESPERA: the play wins -> REGISTRA, no db_timeout.
//  - iniciar outside INICIAL/FIM is ignored. Held button produces exactly one registra.
//  - Unused codes 9..E -> INICIAL next cycle.
//  - Every strobe is exactly one cycle wide.
//  - Latency: press to registra = 1 cycle; release to compare = 1 cycle.
// STRUCTURE
//  - mindfocus_pkg: 4-bit state localparams (INICIAL..FIM), shared with the top-level 7-seg state decoder.
//  - One sub-module, mindfocus_timer: clear/enable counter with terminal-count output, parameter TIMEOUT_CICLOS.
//  - FSM = state register + next-state logic + output decode in this module.
// TESTING
//  1 reset=0 while in SOLTA -> db_estado=0 within the same cycle, all strobes 0; reset=1 -> stays in INICIAL.
//  2 iniciar=1 one cycle -> db_estado 0,1,2; the three zera_* strobes high only in state 1.
//  3 ESPERA, tem_jogada=1 for 10 cycles, igual=1, fim_contagem=0 -> states 3, 4 (x9), 5, 6, 7, 8, 2;
//    registra, conta_acertos and conta_contador each pulse once.
//  4 Same stimulus with igual=0 -> 3, 4.., 5, 7, 8, 2; conta_acertos never asserts.
//  5 TIMEOUT_CICLOS=8, no press -> 8 cycles in ESPERA, then AVANCA with db_timeout pulse;
//    press on the 8th cycle -> REGISTRA, no db_timeout.
//  6 fim_contagem=1 in AVANCA -> FIM, pronto=1 held for 20 cycles; iniciar=1 -> PREPARA, pronto=0.

Source files
------------

// File: rtl/mindfocus_pkg.sv
// mindfocus_pkg: state codes of the game control FSM and its strobe bundle.
// The codes are shared with the top-level 7-segment state decoder.
package mindfocus_pkg;
  localparam logic [3:0] INICIAL  = 4'h0;
  localparam logic [3:0] PREPARA  = 4'h1;
  localparam logic [3:0] ESPERA   = 4'h2;
  localparam logic [3:0] REGISTRA = 4'h3;
  localparam logic [3:0] SOLTA    = 4'h4;
  localparam logic [3:0] COMPARA  = 4'h5;
  localparam logic [3:0] ACERTO   = 4'h6;
  localparam logic [3:0] AVANCA   = 4'h7;
  localparam logic [3:0] PROXIMA  = 4'h8;
  localparam logic [3:0] FIM      = 4'hF;

  typedef struct packed {
    logic zera_contador;
    logic conta_contador;
    logic zera_registro;
    logic registra;
    logic zera_acertos;
    logic conta_acertos;
    logic pronto;
  } ctrl_t;
endpackage

// File: rtl/mindfocus_timer.sv
// mindfocus_timer: per-play timeout counter with clear, enable and terminal count.
// Saturates at TIMEOUT_CICLOS-1 so the terminal count stays asserted until cleared.
module mindfocus_timer #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic fim_o
);
  logic [TW-1:0] cnt_q;

  assign fim_o = (cnt_q == TW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clock or negedge reset)
    if (!reset)               cnt_q <= '0;
    else if (clr_i)           cnt_q <= '0;
    else if (en_i && !fim_o)  cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/mindfocus_unidade_controle.sv
// mindfocus_unidade_controle: Moore FSM sequencing the mindfocus datapath.
// All outputs decode the registered state; db_timeout comes from a registered flag.
module mindfocus_unidade_controle
  import mindfocus_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registro,
  output logic       registra,
  output logic       zera_acertos,
  output logic       conta_acertos,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);
  logic [3:0] estado_q, estado_d;
  logic       timeout_q, timeout_d;
  logic       em_espera, fim_tempo;
  ctrl_t      ctrl;

  assign em_espera = (estado_q == ESPERA);

  // Held low outside ESPERA, so every entry into ESPERA starts from zero.
  mindfocus_timer #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .TW            (TW)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clr_i(!em_espera),
    .en_i (em_espera),
    .fim_o(fim_tempo)
  );

  // A press in the same cycle as the timeout wins over the timeout.
  assign timeout_d = em_espera && !tem_jogada && fim_tempo;

  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:  estado_d = iniciar ? PREPARA : INICIAL;
      PREPARA:  estado_d = ESPERA;
      ESPERA:   estado_d = tem_jogada ? REGISTRA : (fim_tempo ? AVANCA : ESPERA);
      REGISTRA: estado_d = SOLTA;
      SOLTA:    estado_d = tem_jogada ? SOLTA : COMPARA;
      COMPARA:  estado_d = igual ? ACERTO : AVANCA;
      ACERTO:   estado_d = AVANCA;
      AVANCA:   estado_d = fim_contagem ? FIM : PROXIMA;
      PROXIMA:  estado_d = ESPERA;
      FIM:      estado_d = iniciar ? PREPARA : FIM;
      default:  estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado_q  <= INICIAL;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timeout_q <= timeout_d;
    end

  always_comb begin
    ctrl               = '0;
    ctrl.zera_contador = (estado_q == PREPARA);
    ctrl.zera_registro = (estado_q == PREPARA);
    ctrl.zera_acertos  = (estado_q == PREPARA);
    ctrl.registra      = (estado_q == REGISTRA);
    ctrl.conta_acertos = (estado_q == ACERTO);
    ctrl.conta_contador = (estado_q == PROXIMA);
    ctrl.pronto        = (estado_q == FIM);
  end

  assign {zera_contador, conta_contador, zera_registro, registra,
          zera_acertos, conta_acertos, pronto} = ctrl;
  assign db_timeout = timeout_q;
  assign db_estado  = estado_q;
endmodule

// File: tb/tb_mindfocus_unidade_controle.sv
// tb_mindfocus_unidade_controle: scenario tasks drive the FSM cycle by cycle,
// pushing expected state/strobes to a scoreboard popped after each clock edge.
module tb_mindfocus_unidade_controle;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iniciar = 1'b0, tem_jogada = 1'b0, igual = 1'b0, fim_contagem = 1'b0;
  logic zera_contador, conta_contador, zera_registro, registra;
  logic zera_acertos, conta_acertos, pronto, db_timeout;
  logic [3:0] db_estado;

  typedef struct packed {
    logic ini, tem, igu, fim;
  } stim_t;

  stim_t       stq[$];
  logic [11:0] sb[$];
  int          n_cmp = 0, n_err = 0;

  mindfocus_unidade_controle #(.TIMEOUT_CICLOS(8), .TW(4)) dut (
    .clock(clk), .reset(rst_n), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .igual(igual), .fim_contagem(fim_contagem), .zera_contador(zera_contador),
    .conta_contador(conta_contador), .zera_registro(zera_registro),
    .registra(registra), .zera_acertos(zera_acertos), .conta_acertos(conta_acertos),
    .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {db_estado, zera_contador, conta_contador, zera_registro, registra,
            zera_acertos, conta_acertos, pronto, db_timeout};
  endfunction

  // Expected {state, zc, cc, zr, reg, za, ca, pronto, timeout} straight from the state table.
  function automatic logic [11:0] expect_of(input logic [3:0] st, input logic tmo);
    logic [7:0] o;
    o = (st == 4'h1) ? 8'b1010_1000 :
        (st == 4'h3) ? 8'b0001_0000 :
        (st == 4'h6) ? 8'b0000_0100 :
        (st == 4'h8) ? 8'b0100_0000 :
        (st == 4'hF) ? 8'b0000_0010 : 8'b0;
    return {st, o[7:1], tmo};
  endfunction

  task automatic add(input logic ini, tem, igu, fim, input logic [3:0] st, input logic tmo);
    stq.push_back('{ini, tem, igu, fim});
    sb.push_back(expect_of(st, tmo));
  endtask

  task automatic test_reset();
    logic [11:0] e, got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(expect_of(4'h0, 1'b0));
    e = sb.pop_front(); got = observed(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL reset_hold got=%h want=%h", got, e); end
    rst_n = 1'b1;
    repeat (3) add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL reset_idle got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_start();
    logic [11:0] e, got;
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL start got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_play(input logic hit);
    logic [11:0] e, got;
    add(1'b0, 1'b1, hit, 1'b0, 4'h3, 1'b0);
    for (int i = 0; i < 9; i++) add(i[0], 1'b1, hit, 1'b0, 4'h4, 1'b0);
    add(1'b0, 1'b0, hit, 1'b0, 4'h5, 1'b0);
    if (hit) add(1'b0, 1'b0, hit, 1'b0, 4'h6, 1'b0);
    add(1'b0, 1'b0, hit, 1'b0, 4'h7, 1'b0);
    add(1'b0, 1'b0, hit, 1'b0, 4'h8, 1'b0);
    add(1'b0, 1'b0, hit, 1'b0, 4'h2, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL play_%s got=%h want=%h", hit ? "hit" : "miss", got, e); end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] e, got;
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL timeout got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e, got;
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL to_solta got=%h want=%h", got, e); end
    end
    rst_n = 1'b0;
    sb.push_back(expect_of(4'h0, 1'b0));
    #1;
    e = sb.pop_front(); got = observed(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL async_reset got=%h want=%h", got, e); end
    tem_jogada = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL after_reset got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_fim();
    logic [11:0] e, got;
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0);
    repeat (20) add(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
    while (stq.size() > 0) begin
      {iniciar, tem_jogada, igual, fim_contagem} = stq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); got = observed(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL fim got=%h want=%h", got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_play(1'b1);
    test_play(1'b0);
    test_timeout();
    test_reset_mid();
    test_fim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
